mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle MIPS control unit that sequences the shared 32-bit ALU, register file, PC and unified memory of the multi-cycle CPU. A Moore-style FSM steps each instruction through fetch/decode/execute/memory/write-back and drives every datapath select, write-enable and the 3-bit `ALU_Ctr` code per cycle. Memory accesses are stalled by a ready handshake. Sits beside the datapath in the CPU top, fed by IR fields and the ALU `zero` flag.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag from the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable, with branch condition already folded in.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: IR load.
- `reg_write` out 1: register file write.
- `reg_dst` out 2: destination select. 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: write-back data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = regA.
- `alu_src_b` out 2: ALU B select. 00 = regB, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_ctr` out 3: ALU operation code.
- `pc_source` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 5: current state, for debug display.

## Operation
- `alu_ctr` codes: AND 000, OR 001, ADD 010, NOR 011, XOR 101, SUB 110, SLT 111.
- Supported R-type funct values: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010.
- Supported opcodes: lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000, andi 001100, ori 001101, slti 001010.
- Outputs are decoded from `state`. Only `pc_write`/`ir_write` in IF also depend on `mem_ready`, and branch `pc_write` also depends on `zero`. All unlisted enables are 0 and all selects are 0.
- State transitions and per-state outputs:
  - IF (0): `mem_read`=1, `alu_src_b`=01, `alu_ctr`=ADD, `ir_write`=`pc_write`=`mem_ready`. Go to ID when `mem_ready`=1, else hold.
  - ID (1): `alu_src_b`=11, `alu_ctr`=ADD (branch target into ALUOut). Dispatch on opcode.
  - MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, ADD. Go to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (3): `iord`=1, `mem_read`=1. Hold until `mem_ready`, then go to LW_WB.
  - LW_WB (4): `reg_write`=1, `mem_to_reg`=01, `reg_dst`=00. Go to IF.
  - MEM_WR (5): `iord`=1, `mem_write`=1. Hold until `mem_ready`, then go to IF.
  - R_EX (6): `alu_src_a`=1, `alu_src_b`=00, `alu_ctr` from funct. Go to R_WB.
  - R_WB (7): `reg_write`=1, `reg_dst`=01. Go to IF.
  - BEQ (8) / BNE (13): `alu_src_a`=1, SUB, `pc_source`=01, `pc_write`=`zero` (BEQ) or `~zero` (BNE). Go to IF.
  - J (9): `pc_source`=10, `pc_write`=1. Go to IF.
  - JAL (12): J outputs plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. Go to IF.
  - I_EX (10): `alu_src_a`=1, `alu_src_b`=10, `alu_ctr` from opcode (addi ADD, andi AND, ori OR, slti SLT). Go to I_WB.
  - I_WB (11): `reg_write`=1, `reg_dst`=00. Go to IF.
- Unknown opcode, or unknown funct with opcode 000000: ID returns to IF with no write. The instruction executes as a NOP.

## Timing
- Instruction latency in cycles, with zero-wait memory:
  - R-type and I-ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j, jal: 3.
- Each low cycle of `mem_ready` in IF, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted and the address stays stable throughout the stall.
- `rst` asserted, at any time including mid-instruction or mid-stall: `state`=IF immediately (asynchronous). Outputs take IF values: `mem_read`=1, `alu_src_b`=01, `alu_ctr`=010, all other outputs 0, `ir_write`/`pc_write` gated by `mem_ready`.
- First fetch completes on the first rising edge after `rst` deasserts with `mem_ready`=1.
- `zero` is sampled combinationally in BEQ/BNE. The PC update happens on that state's closing edge.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - 5-bit state constants.
  - `alu_ctr` codes.
  - opcode and funct constants.
  - select encodings for `reg_dst`, `mem_to_reg`, `alu_src_b`, `pc_source`.
- One sub-module, `alu_dec`: combinational mapping of (state, opcode, funct) to `alu_ctr`.

## Test plan
- Reset mid-MEM_RD stall: assert `rst` → `state`=0 the same cycle, `mem_write`=0, `reg_write`=0, `alu_ctr`=010.
- R-type add (opcode 0, funct 100000), `mem_ready`=1: states 0→1→6→7→0. `alu_ctr`=010 in R_EX. `reg_write`=1 and `reg_dst`=01 in R_WB only.
- lw with `mem_ready` low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0. `iord`=1 and `mem_read`=1 held through all three MEM_RD cycles.
- beq with `zero`=1 → `pc_write`=1 and `pc_source`=01 in state 8. Repeat with `zero`=0 → `pc_write`=0. Same for bne with inverted result.
- jal: state 12 drives `pc_write`=1, `pc_source`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, then returns to 0.
- Illegal opcode 111111 and slti: the illegal opcode goes 0→1→0 with no writes. slti gives `alu_ctr`=111 in I_EX, then `reg_write`=1 with `reg_dst`=00.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// ALU operation codes, opcode/funct values and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF       = 5'd0,
        S_ID       = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_LW_WB    = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EX     = 5'd6,
        S_R_WB     = 5'd7,
        S_BEQ      = 5'd8,
        S_J        = 5'd9,
        S_I_EX     = 5'd10,
        S_I_WB     = 5'd11,
        S_JAL      = 5'd12,
        S_BNE      = 5'd13
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type funct values (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Write-back data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // True for the R-type funct values the datapath supports
    function automatic logic funct_supported(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: funct_supported = 1'b1;
            default:                                               funct_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU operation decoder: maps the current FSM state plus IR fields to the
// 3-bit ALU control code. Purely combinational.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [4:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctr
);

    // Select the ALU operation for the state being executed
    always_comb begin
        o_alu_ctr = ALU_AND;
        case (i_state)
            S_IF, S_ID, S_MEM_ADDR: o_alu_ctr = ALU_ADD;
            S_BEQ, S_BNE:           o_alu_ctr = ALU_SUB;
            S_R_EX: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctr = ALU_ADD;
                    FN_SUB:  o_alu_ctr = ALU_SUB;
                    FN_AND:  o_alu_ctr = ALU_AND;
                    FN_OR:   o_alu_ctr = ALU_OR;
                    FN_XOR:  o_alu_ctr = ALU_XOR;
                    FN_NOR:  o_alu_ctr = ALU_NOR;
                    FN_SLT:  o_alu_ctr = ALU_SLT;
                    default: o_alu_ctr = ALU_ADD;
                endcase
            end
            S_I_EX: begin
                case (i_opcode)
                    OP_ADDI: o_alu_ctr = ALU_ADD;
                    OP_ANDI: o_alu_ctr = ALU_AND;
                    OP_ORI:  o_alu_ctr = ALU_OR;
                    OP_SLTI: o_alu_ctr = ALU_SLT;
                    default: o_alu_ctr = ALU_ADD;
                endcase
            end
            default: o_alu_ctr = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. Moore FSM that sequences fetch, decode,
// execute, memory and write-back, driving every datapath select and enable.
// Memory states hold while mem_ready is low so strobes and iord stay stable
// across a stall. The only input-dependent outputs are the IF-state
// pc_write/ir_write (gated by mem_ready) and branch pc_write (gated by zero).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctr,
    output logic [1:0] pc_source,
    output logic [4:0] state
);

    state_t r_state;
    state_t w_next;

    assign state = r_state;

    alu_dec u_alu_dec (
        .i_state   (r_state),
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_alu_ctr (alu_ctr)
    );

    // State register; reset forces an immediate return to fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IF;
        else     r_state <= w_next;
    end

    // Next-state logic and per-state datapath controls
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_source  = PCS_ALU;

        case (r_state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // ALU precomputes PC + (imm << 2) into ALUOut for branches
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:                         w_next = funct_supported(funct) ? S_R_EX : S_IF;
                    OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
                    OP_BEQ:                           w_next = S_BEQ;
                    OP_BNE:                           w_next = S_BNE;
                    OP_J:                             w_next = S_J;
                    OP_JAL:                           w_next = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_I_EX;
                    default:                          w_next = S_IF;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                w_next   = mem_ready ? S_LW_WB : S_MEM_RD;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                reg_dst    = RD_RT;
                w_next     = S_IF;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                w_next    = mem_ready ? S_IF : S_MEM_WR;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
                w_next    = S_IF;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                pc_source = PCS_ALUOUT;
                pc_write  = zero;
                w_next    = S_IF;
            end
            S_BNE: begin
                alu_src_a = 1'b1;
                pc_source = PCS_ALUOUT;
                pc_write  = ~zero;
                w_next    = S_IF;
            end
            S_J: begin
                pc_source = PCS_JUMP;
                pc_write  = 1'b1;
                w_next    = S_IF;
            end
            S_JAL: begin
                // Jump and link: return address (PC) written to $31
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
                w_next     = S_IF;
            end
            S_I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RT;
                w_next    = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl. Each cycle the driver pushes the expected output
// vector (from a reference table of per-state outputs) and the sampled DUT
// output vector; each test task then drains the queues and compares.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic [1:0] pc_source;
    logic [4:0] state;

    int errors = 0;
    int checks = 0;

    logic [22:0] exp_q[$];
    logic [22:0] act_q[$];

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctr    (alu_ctr),
        .pc_source  (pc_source),
        .state      (state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference outputs for a given state and inputs, straight from the
    // control table. Packed as {state, pcw, iord, mrd, mwr, irw, rw,
    // reg_dst, mem_to_reg, src_a, src_b, alu_ctr, pc_source}.
    function automatic logic [22:0] exp_out(input logic [4:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic rdy, input logic z);
        logic pcw, io, mrd, mwr, irw, rw, sa;
        logic [1:0] rdst, m2r, sb, pcs;
        logic [2:0] alu;
        pcw = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; sa = 0;
        rdst = 0; m2r = 0; sb = 0; pcs = 0; alu = 3'b000;
        case (st)
            5'd0:  begin mrd = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
            5'd1:  begin sb = 2'b11; alu = 3'b010; end
            5'd2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            5'd3:  begin io = 1; mrd = 1; end
            5'd4:  begin rw = 1; m2r = 2'b01; end
            5'd5:  begin io = 1; mwr = 1; end
            5'd6:  begin
                sa = 1;
                case (fn)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b100110: alu = 3'b101;
                    6'b100111: alu = 3'b011;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'bxxx;
                endcase
            end
            5'd7:  begin rw = 1; rdst = 2'b01; end
            5'd8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcw = z; end
            5'd13: begin sa = 1; alu = 3'b110; pcs = 2'b01; pcw = ~z; end
            5'd9:  begin pcs = 2'b10; pcw = 1; end
            5'd12: begin pcs = 2'b10; pcw = 1; rw = 1; rdst = 2'b10; m2r = 2'b10; end
            5'd10: begin
                sa = 1; sb = 2'b10;
                case (op)
                    6'b001000: alu = 3'b010;
                    6'b001100: alu = 3'b000;
                    6'b001101: alu = 3'b001;
                    6'b001010: alu = 3'b111;
                    default:   alu = 3'bxxx;
                endcase
            end
            5'd11: begin rw = 1; end
            default: ;
        endcase
        return {st, pcw, io, mrd, mwr, irw, rw, rdst, m2r, sa, sb, alu, pcs};
    endfunction

    // Drive one cycle (entered #1 after a rising edge), record expected and
    // observed outputs at the falling edge, then advance past the next edge.
    task automatic drive_cycle(input logic rdy, input logic z, input logic [4:0] exp_st);
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(exp_out(exp_st, opcode, funct, rdy, z));
        @(negedge clk);
        act_q.push_back({state, pc_write, iord, mem_read, mem_write, ir_write, reg_write,
                         reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctr, pc_source});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if ({pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_b, alu_ctr} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010}) begin
            errors++;
            $display("FAIL reset_outputs: got pcw=%b irw=%b mrd=%b mwr=%b rw=%b srcb=%b alu=%b expected 0 0 1 0 0 01 010",
                     pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_b, alu_ctr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({pc_write, ir_write} !== 2'b11) begin errors++; $display("FAIL reset_if_gating: got pcw/irw=%b%b expected 11", pc_write, ir_write); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_rtype;
        logic [22:0] e, a;
        opcode = 6'b000000;
        funct  = 6'b100000;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 6); drive_cycle(1, 0, 7);
        funct = 6'b100111;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 6); drive_cycle(1, 0, 7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL rtype: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL rtype_return: got %0d expected 0", state); end
    endtask

    task automatic test_lw_stall;
        logic [22:0] e, a;
        opcode = 6'b100011;
        funct  = 6'b010101;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 2);
        drive_cycle(0, 0, 3); drive_cycle(0, 0, 3); drive_cycle(1, 0, 3); drive_cycle(1, 0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL lw_stall: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL lw_return: got %0d expected 0", state); end
    endtask

    task automatic test_branch;
        logic [22:0] e, a;
        funct = 6'd0;
        for (int i = 0; i < 4; i++) begin
            opcode = (i < 2) ? 6'b000100 : 6'b000101;
            drive_cycle(1, 0, 0);
            drive_cycle(1, 0, 1);
            drive_cycle(1, logic'(i % 2 == 0), (i < 2) ? 5'd8 : 5'd13);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL branch: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL branch_return: got %0d expected 0", state); end
    endtask

    task automatic test_jump;
        logic [22:0] e, a;
        opcode = 6'b000011;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 12);
        opcode = 6'b000010;
        drive_cycle(1, 1, 0); drive_cycle(1, 1, 1); drive_cycle(1, 1, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL jump: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL jump_return: got %0d expected 0", state); end
    endtask

    task automatic test_illegal_and_itype;
        logic [22:0] e, a;
        opcode = 6'b111111;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1);
        opcode = 6'b000000; funct = 6'b111111;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1);
        opcode = 6'b001010;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 10); drive_cycle(1, 0, 11);
        opcode = 6'b001101;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 10); drive_cycle(1, 0, 11);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL illegal_itype: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL itype_return: got %0d expected 0", state); end
    endtask

    task automatic test_back_to_back;
        logic [22:0] e, a;
        int k;
        funct = 6'd0;
        for (int n = 0; n < 8; n++) begin
            opcode = (n % 2 == 0) ? 6'b101011 : 6'b100011;
            k = int'($urandom_range(0, 3));
            for (int s = 0; s < k; s++) drive_cycle(0, 0, 0);
            drive_cycle(1, 0, 0);
            drive_cycle(1, 0, 1);
            drive_cycle(1, 0, 2);
            k = int'($urandom_range(0, 3));
            for (int s = 0; s < k; s++) drive_cycle(0, 0, (n % 2 == 0) ? 5'd5 : 5'd3);
            drive_cycle(1, 0, (n % 2 == 0) ? 5'd5 : 5'd3);
            if (n % 2 == 1) drive_cycle(1, 0, 4);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL back_to_back: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL b2b_return: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid_stall;
        logic [22:0] e, a;
        opcode = 6'b100011;
        drive_cycle(1, 0, 0); drive_cycle(1, 0, 1); drive_cycle(1, 0, 2); drive_cycle(0, 0, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL pre_reset: got %h expected %h", a, e); end
        end
        checks++;
        if (state !== 5'd3) begin errors++; $display("FAIL stall_state: got %0d expected 3", state); end
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 5'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", state); end
        checks++;
        if ({mem_write, reg_write, alu_ctr, mem_read, iord, ir_write} !== {1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_outputs: got mwr=%b rw=%b alu=%b mrd=%b iord=%b irw=%b expected 0 0 010 1 0 0",
                     mem_write, reg_write, alu_ctr, mem_read, iord, ir_write);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 5'd1) begin errors++; $display("FAIL first_fetch: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_jump();
        test_illegal_and_itype();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
